// File: rtl/rr_arb_pkt_pkg.sv
// rr_arb_pkt_pkg
//   Shared definitions for the cd_mesh round-robin packet arbiter:
//   arbiter state encoding, default router port count and an index-width
//   helper that never returns less than one bit.
package rr_arb_pkt_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arbState_e;

  localparam int DEFAULT_N = 8;

  // Index width for an N-entry vector; a 1-requester or 2-requester
  // arbiter still needs one bit to carry an index.
  function automatic int clog2Min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_pkt_pick.sv
// rr_arb_pkt_pick
//   Purely combinational round-robin pick: finds the first asserted request
//   searching i_ptr, i_ptr+1, ..., N-1, 0, ..., i_ptr-1.
//   Ports:
//     i_req    [N]    per-requester request
//     i_ptr    [IDXW] search start position (0..N-1)
//     o_win    [N]    one-hot winner, all-zero when nothing is requested
//     o_winIdx [IDXW] winner index, 0 when nothing is requested
//     o_any           at least one request is asserted
module rr_arb_pkt_pick
  import rr_arb_pkt_pkg::*;
#(
  parameter int N = DEFAULT_N,
  localparam int IDXW = clog2Min1(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [N-1:0]    o_win,
  output logic [IDXW-1:0] o_winIdx,
  output logic            o_any
);

  logic [N-1:0]   w_maskAtOrAbove;
  logic [2*N-1:0] w_dbl;
  logic           w_found;

  // Lower half holds only requests at or above the pointer, upper half the
  // full request vector, so a single lowest-bit priority encode over the
  // doubled vector gives the wrapped search order without rotation muxes.
  always_comb begin
    w_maskAtOrAbove = '0;
    for (int i = 0; i < N; i++) begin
      w_maskAtOrAbove[i] = (IDXW'(i) >= i_ptr);
    end
    w_dbl = {i_req, i_req & w_maskAtOrAbove};
  end

  always_comb begin
    w_found  = 1'b0;
    o_winIdx = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!w_found && w_dbl[j]) begin
        w_found  = 1'b1;
        o_winIdx = (j < N) ? IDXW'(j) : IDXW'(j - N);
      end
    end
    o_any = w_found;
    o_win = w_found ? (N'(1) << o_winIdx) : '0;
  end

endmodule

// File: rtl/rr_arb_pkt.sv
// rr_arb_pkt
//   N-way round-robin arbiter with packet-level grant locking for cd_mesh
//   output-port and VC allocation. A requester granted with a non-tail flit
//   owns the channel until its tail flit is granted; an optional timeout
//   releases an owner that stops requesting. Grant is combinational from
//   registered state (zero-cycle arbitration).
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     i_req    [N]    per-requester request
//     i_last   [N]    current flit is the tail (meaningful with i_req)
//     i_en            downstream accepts a flit this cycle
//     o_gnt    [N]    one-hot grant or all-zero
//     o_gntVld        |o_gnt
//     o_gntIdx [IDXW] encode of o_gnt, 0 when no grant
//     o_locked        arbiter is in the LOCKED state
//     o_owner  [IDXW] current lock owner, valid while o_locked
//     o_tmo           one-cycle pulse after a timeout release
module rr_arb_pkt
  import rr_arb_pkt_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int LOCK_TMO = 0,
  parameter int TMOW = 8,
  localparam int IDXW = clog2Min1(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    i_req,
  input  logic [N-1:0]    i_last,
  input  logic            i_en,
  output logic [N-1:0]    o_gnt,
  output logic            o_gntVld,
  output logic [IDXW-1:0] o_gntIdx,
  output logic            o_locked,
  output logic [IDXW-1:0] o_owner,
  output logic            o_tmo
);

  // Counter value on the last idle cycle before release; unused when the
  // timeout is disabled.
  localparam logic [TMOW-1:0] TMO_LAST = (LOCK_TMO > 0) ? TMOW'(LOCK_TMO - 1) : '0;

  arbState_e       r_state, w_nextState;
  logic [IDXW-1:0] r_ptr, w_nextPtr;
  logic [IDXW-1:0] r_owner, w_nextOwner;
  logic [TMOW-1:0] r_cnt, w_nextCnt;
  logic            r_tmo, w_nextTmo;

  logic [N-1:0]    w_pickWin;
  logic [IDXW-1:0] w_pickIdx;
  logic            w_pickAny;
  logic            w_ownerReq;
  logic            w_ownerLast;
  logic [N-1:0]    w_gnt;

  rr_arb_pkt_pick #(.N(N)) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_win    (w_pickWin),
    .o_winIdx (w_pickIdx),
    .o_any    (w_pickAny)
  );

  // Next-state and grant logic. In LOCKED only the owner can be granted and
  // the pointer is frozen at owner+1, so the next free arbitration resumes
  // just past the packet that held the channel.
  always_comb begin
    w_nextState = r_state;
    w_nextPtr   = r_ptr;
    w_nextOwner = r_owner;
    w_nextCnt   = r_cnt;
    w_nextTmo   = 1'b0;
    w_gnt       = '0;
    w_ownerReq  = i_req[r_owner];
    w_ownerLast = i_last[r_owner];

    case (r_state)
      ARB_IDLE: begin
        w_nextCnt = '0;
        if (i_en && w_pickAny) begin
          w_gnt     = w_pickWin;
          w_nextPtr = (w_pickIdx == IDXW'(N - 1)) ? '0 : w_pickIdx + IDXW'(1);
          if (!i_last[w_pickIdx]) begin
            w_nextState = ARB_LOCKED;
            w_nextOwner = w_pickIdx;
          end
        end
      end

      ARB_LOCKED: begin
        if (w_ownerReq) begin
          // A requesting owner is either granted or backpressured; neither
          // counts as idle.
          w_nextCnt = '0;
          if (i_en) begin
            w_gnt = N'(1) << r_owner;
            if (w_ownerLast) begin
              w_nextState = ARB_IDLE;
            end
          end
        end else if (LOCK_TMO > 0) begin
          if (r_cnt == TMO_LAST) begin
            w_nextState = ARB_IDLE;
            w_nextCnt   = '0;
            w_nextTmo   = 1'b1;
          end else begin
            w_nextCnt = r_cnt + TMOW'(1);
          end
        end
      end

      default: begin
        w_nextState = ARB_IDLE;
      end
    endcase

    if (reset) begin
      w_gnt = '0;
    end
  end

  // All arbiter state in one register process.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_owner <= w_nextOwner;
      r_cnt   <= w_nextCnt;
      r_tmo   <= w_nextTmo;
    end
  end

  // Index is derived from the grant itself so the two can never disagree.
  always_comb begin
    o_gntIdx = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gnt[k]) begin
        o_gntIdx = IDXW'(k);
      end
    end
  end

  assign o_gnt    = w_gnt;
  assign o_gntVld = |w_gnt;
  assign o_locked = (r_state == ARB_LOCKED);
  assign o_owner  = r_owner;
  assign o_tmo    = r_tmo;

endmodule

// File: tb/tb_rr_arb_pkt.sv
// tb_rr_arb_pkt
//   Self-checking bench for rr_arb_pkt. Instance A is N=8 with LOCK_TMO=4,
//   instance B is N=5 with the timeout disabled. Expected outputs are queued
//   as each cycle's stimulus is driven and compared once the cycle is sampled.
module tb_rr_arb_pkt;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       locked;
    logic       tmo;
  } expT;

  logic       clk;
  logic       reset;
  logic [7:0] aReq, aLast, aGnt;
  logic       aEn, aVld, aLocked, aTmo;
  logic [2:0] aIdx, aOwner;
  logic [4:0] bReq, bLast, bGnt;
  logic       bEn, bVld, bLocked, bTmo;
  logic [2:0] bIdx, bOwner;

  logic [7:0] obsGnt;
  logic       obsVld, obsLocked, obsTmo;
  logic [2:0] obsIdx, obsOwner;

  expT expQ[$];
  int  checks = 0;
  int  passed = 0;

  rr_arb_pkt #(.N(8), .LOCK_TMO(4), .TMOW(8)) dutA (
    .clk(clk), .reset(reset), .i_req(aReq), .i_last(aLast), .i_en(aEn),
    .o_gnt(aGnt), .o_gntVld(aVld), .o_gntIdx(aIdx), .o_locked(aLocked),
    .o_owner(aOwner), .o_tmo(aTmo)
  );

  rr_arb_pkt #(.N(5), .LOCK_TMO(0), .TMOW(8)) dutB (
    .clk(clk), .reset(reset), .i_req(bReq), .i_last(bLast), .i_en(bEn),
    .o_gnt(bGnt), .o_gntVld(bVld), .o_gntIdx(bIdx), .o_locked(bLocked),
    .o_owner(bOwner), .o_tmo(bTmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle at the falling edge, queues the expected outputs and
  // samples the selected instance shortly before the next rising edge.
  task automatic applyStimulus(input bit useB, input logic [7:0] req, input logic [7:0] last,
                               input logic en, input logic rst, input logic [7:0] expGnt,
                               input logic expLocked, input logic expTmo);
    expT e;
    @(negedge clk);
    reset = rst;
    aReq  = useB ? 8'h00 : req;
    aLast = useB ? 8'h00 : last;
    aEn   = useB ? 1'b0 : en;
    bReq  = useB ? req[4:0] : 5'h00;
    bLast = useB ? last[4:0] : 5'h00;
    bEn   = useB ? en : 1'b0;
    e.gnt = expGnt;
    e.idx = 3'd0;
    for (int k = 0; k < 8; k++) if (expGnt[k]) e.idx = 3'(k);
    e.locked = expLocked;
    e.tmo    = expTmo;
    expQ.push_back(e);
    #2;
    obsGnt    = useB ? {3'b000, bGnt} : aGnt;
    obsVld    = useB ? bVld : aVld;
    obsIdx    = useB ? bIdx : aIdx;
    obsLocked = useB ? bLocked : aLocked;
    obsTmo    = useB ? bTmo : aTmo;
    obsOwner  = useB ? bOwner : aOwner;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    aReq = '0; aLast = '0; aEn = 1'b0;
    bReq = '0; bLast = '0; bEn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    expT e;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({obsGnt, obsVld, obsIdx, obsLocked, obsTmo} !== {e.gnt, |e.gnt, e.idx, e.locked, e.tmo})
        $display("[TB] FAIL reset cyc%0d: got gnt=%h vld=%b idx=%0d locked=%b tmo=%b, expected gnt=%h vld=%b idx=%0d locked=%b tmo=%b",
                 i, obsGnt, obsVld, obsIdx, obsLocked, obsTmo, e.gnt, |e.gnt, e.idx, e.locked, e.tmo);
      else passed++;
      checks++;
      if (obsOwner !== 3'd0) $display("[TB] FAIL reset_owner: got %0d, expected 0", obsOwner);
      else passed++;
    end
  endtask

  task automatic test_rotation();
    expT e;
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'(1 << (i % 8)), 1'b0, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({obsGnt, obsVld, obsIdx, obsLocked, obsTmo} !== {e.gnt, |e.gnt, e.idx, e.locked, e.tmo})
        $display("[TB] FAIL rotation cyc%0d: got gnt=%h vld=%b idx=%0d locked=%b tmo=%b, expected gnt=%h vld=%b idx=%0d locked=%b tmo=%b",
                 i, obsGnt, obsVld, obsIdx, obsLocked, obsTmo, e.gnt, |e.gnt, e.idx, e.locked, e.tmo);
      else passed++;
    end
  endtask

  task automatic test_packet_lock();
    expT e;
    logic [7:0] reqT  [6] = '{8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h00};
    logic [7:0] lastT [6] = '{8'h08, 8'h08, 8'h08, 8'h0A, 8'h0A, 8'h00};
    logic [7:0] gntT  [6] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h08, 8'h00};
    logic       lockT [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, reqT[i], lastT[i], 1'b1, 1'b0, gntT[i], lockT[i], 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({obsGnt, obsVld, obsIdx, obsLocked, obsTmo} !== {e.gnt, |e.gnt, e.idx, e.locked, e.tmo})
        $display("[TB] FAIL packet_lock cyc%0d: got gnt=%h vld=%b idx=%0d locked=%b tmo=%b, expected gnt=%h vld=%b idx=%0d locked=%b tmo=%b",
                 i, obsGnt, obsVld, obsIdx, obsLocked, obsTmo, e.gnt, |e.gnt, e.idx, e.locked, e.tmo);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    expT e;
    logic [7:0] reqT  [8] = '{8'h04, 8'h24, 8'h24, 8'h24, 8'h20, 8'h20, 8'h24, 8'h20};
    logic [7:0] lastT [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h20};
    logic       enT   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] gntT  [8] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h20};
    logic       lockT [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, reqT[i], lastT[i], enT[i], 1'b0, gntT[i], lockT[i], 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({obsGnt, obsVld, obsIdx, obsLocked, obsTmo} !== {e.gnt, |e.gnt, e.idx, e.locked, e.tmo})
        $display("[TB] FAIL backpressure cyc%0d: got gnt=%h vld=%b idx=%0d locked=%b tmo=%b, expected gnt=%h vld=%b idx=%0d locked=%b tmo=%b",
                 i, obsGnt, obsVld, obsIdx, obsLocked, obsTmo, e.gnt, |e.gnt, e.idx, e.locked, e.tmo);
      else passed++;
      if (lockT[i]) begin
        checks++;
        if (obsOwner !== 3'd2) $display("[TB] FAIL backpressure_owner cyc%0d: got %0d, expected 2", i, obsOwner);
        else passed++;
      end
    end
  endtask

  task automatic test_timeout();
    expT e;
    logic [7:0] reqT  [7] = '{8'h40, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    logic [7:0] lastT [7] = '{8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    logic [7:0] gntT  [7] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80};
    logic       lockT [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       tmoT  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, reqT[i], lastT[i], 1'b1, 1'b0, gntT[i], lockT[i], tmoT[i]);
      e = expQ.pop_front();
      checks++;
      if ({obsGnt, obsVld, obsIdx, obsLocked, obsTmo} !== {e.gnt, |e.gnt, e.idx, e.locked, e.tmo})
        $display("[TB] FAIL timeout cyc%0d: got gnt=%h vld=%b idx=%0d locked=%b tmo=%b, expected gnt=%h vld=%b idx=%0d locked=%b tmo=%b",
                 i, obsGnt, obsVld, obsIdx, obsLocked, obsTmo, e.gnt, |e.gnt, e.idx, e.locked, e.tmo);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_packet();
    expT e;
    logic [7:0] reqT  [4] = '{8'h08, 8'h08, 8'hFF, 8'hFF};
    logic [7:0] lastT [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    logic       rstT  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] gntT  [4] = '{8'h08, 8'h08, 8'h00, 8'h01};
    logic       lockT [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] ownT  [4] = '{3'd0, 3'd3, 3'd3, 3'd0};
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, reqT[i], lastT[i], 1'b1, rstT[i], gntT[i], lockT[i], 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({obsGnt, obsVld, obsIdx, obsLocked, obsTmo} !== {e.gnt, |e.gnt, e.idx, e.locked, e.tmo})
        $display("[TB] FAIL reset_mid cyc%0d: got gnt=%h vld=%b idx=%0d locked=%b tmo=%b, expected gnt=%h vld=%b idx=%0d locked=%b tmo=%b",
                 i, obsGnt, obsVld, obsIdx, obsLocked, obsTmo, e.gnt, |e.gnt, e.idx, e.locked, e.tmo);
      else passed++;
      if (i > 0) begin
        checks++;
        if (obsOwner !== ownT[i]) $display("[TB] FAIL reset_mid_owner cyc%0d: got %0d, expected %0d", i, obsOwner, ownT[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_wrap_n5();
    expT e;
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h11, 8'h1F, 1'b1, 1'b0, (i % 2 == 0) ? 8'h01 : 8'h10, 1'b0, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({obsGnt, obsVld, obsIdx, obsLocked, obsTmo} !== {e.gnt, |e.gnt, e.idx, e.locked, e.tmo})
        $display("[TB] FAIL wrap_n5 cyc%0d: got gnt=%h vld=%b idx=%0d locked=%b tmo=%b, expected gnt=%h vld=%b idx=%0d locked=%b tmo=%b",
                 i, obsGnt, obsVld, obsIdx, obsLocked, obsTmo, e.gnt, |e.gnt, e.idx, e.locked, e.tmo);
      else passed++;
    end
  endtask

  task automatic test_no_timeout();
    expT e;
    logic [7:0] req, last, gnt;
    logic       lck;
    doReset();
    for (int i = 0; i < 13; i++) begin
      if (i == 0) begin
        req = 8'h02; last = 8'h00; gnt = 8'h02; lck = 1'b0;
      end else if (i < 11) begin
        req = 8'h00; last = 8'h00; gnt = 8'h00; lck = 1'b1;
      end else if (i == 11) begin
        req = 8'h06; last = 8'h02; gnt = 8'h02; lck = 1'b1;
      end else begin
        req = 8'h04; last = 8'h04; gnt = 8'h04; lck = 1'b0;
      end
      applyStimulus(1'b1, req, last, 1'b1, 1'b0, gnt, lck, 1'b0);
      e = expQ.pop_front();
      checks++;
      if ({obsGnt, obsVld, obsIdx, obsLocked, obsTmo} !== {e.gnt, |e.gnt, e.idx, e.locked, e.tmo})
        $display("[TB] FAIL no_timeout cyc%0d: got gnt=%h vld=%b idx=%0d locked=%b tmo=%b, expected gnt=%h vld=%b idx=%0d locked=%b tmo=%b",
                 i, obsGnt, obsVld, obsIdx, obsLocked, obsTmo, e.gnt, |e.gnt, e.idx, e.locked, e.tmo);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    aReq = '0; aLast = '0; aEn = 1'b0;
    bReq = '0; bLast = '0; bEn = 1'b0;
    test_reset();
    test_rotation();
    test_packet_lock();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    test_wrap_n5();
    test_no_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Guards against a stuck run; stimulus is a fixed cycle count.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rr_arb_pkt.md
Name: rr_arb_pkt

Overview:
- Parametrised N-way round-robin arbiter with packet-level grant locking, for cd_mesh output-port and VC allocation.
- Once a requester wins with a non-tail flit, the grant stays with it until its tail flit is granted, so packets never interleave on a channel.
- An optional lock timeout releases a stalled owner.
- Grant is combinational from registered state, giving zero-cycle arbitration.

Parameters:
- N, 8, number of requesters (2..32; non-power-of-two allowed).
- IDXW, clog2(N) (minimum 1), width of index outputs; derived, not overridden.
- LOCK_TMO, 0, consecutive owner-idle cycles that force lock release; 0 disables the timeout.
- TMOW, 8, width of the timeout counter; LOCK_TMO must be < 2^TMOW.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  N  per-requester request.
- last  in  N  per-requester flag: the current flit is the tail. Only meaningful while req is high.
- en  in  1  downstream can accept a flit this cycle.
- gnt  out  N  one-hot grant, or all-zero.
- gnt_vld  out  1  equals |gnt.
- gnt_idx  out  IDXW  index of the granted requester; 0 when gnt_vld=0.
- locked  out  1  arbiter is in the LOCKED state.
- owner  out  IDXW  index of the current lock owner; valid only while locked=1.
- tmo  out  1  one-cycle pulse when a lock is released by timeout.

Behaviour:
- Reset: ptr=0, state=IDLE, owner=0, tmo counter=0, tmo=0. While reset=1, gnt=0, gnt_vld=0 and gnt_idx=0.
- Pick function: the first requester found searching ptr, ptr+1, …, N-1, 0, …, ptr-1 with req=1.
- Wrap rule: index arithmetic is modulo N, so (N-1)+1 = 0 even when N is not a power of two.
- en=0 (either state):
  - gnt=0.
  - ptr, state and owner hold.
  - The timeout counter still runs (see LOCKED).
- IDLE, en=1, req≠0:
  - gnt = one-hot(pick).
  - ptr <= pick+1 mod N.
  - If last[pick]=0: go to LOCKED with owner <= pick and counter cleared.
  - If last[pick]=1: stay IDLE (single-flit packet).
- IDLE, req=0: no grant and no state change.
- LOCKED:
  - gnt = one-hot(owner) when req[owner]=1 and en=1, else 0.
  - Other requesters are never granted. ptr does not change.
  - Owner granted with last[owner]=1: go to IDLE next cycle. The next arbitration starts from the ptr saved at lock entry (owner+1).
  - Owner granted with last[owner]=0: stay LOCKED and clear the counter.
- Timeout (LOCK_TMO>0, LOCKED):
  - The counter increments each cycle req[owner]=0; it is cleared on any cycle req[owner]=1.
  - When the counter reaches LOCK_TMO: go to IDLE on that edge, tmo=1 for exactly one cycle (registered), counter cleared.
- Timeout disabled (LOCK_TMO=0): the counter stays 0 and tmo never asserts.
- If en=0 while req[owner]=1, the owner is backpressured, not idle, so the counter is cleared.
- Tail and timeout in the same cycle cannot coincide (the tail needs req[owner]=1).
- Reset mid-packet: immediate return to reset state. The downstream is responsible for the partial packet.
- locked = (state==LOCKED). owner is registered.
- gnt_idx is an encode of gnt, so gnt and gnt_idx are always consistent.
- No latches. All state lives in a single always @(posedge clk) block.

Decomposition:
- Shared header cd_mesh_defs.vh holds:
  - the clog2 function;
  - state encodings ARB_IDLE=1'b0, ARB_LOCKED=1'b1;
  - the default N used by the router ports.
- One sub-module, rr_pick: purely combinational, parametrised N. Inputs req[N] and ptr[IDXW]; outputs one-hot win[N], win_idx and any.
  - Implementation: double-width request mask (req & ~mask-below-ptr, then plain req) plus a priority encode. No explicit rotation muxes.
- The rr_arb_pkt top holds the FSM, ptr, owner, timeout counter and output muxing.

Test Plan:
- Rotation: N=8, req=8'hFF, last=8'hFF, en=1 for 10 cycles -> gnt_idx sequence 0,1,…,7,0,1; locked stays 0.
- Non-power-of-two wrap: N=5, req=5'b10001, last=all 1 -> gnt_idx 0,4,0,4; ptr never reaches 5–7.
- Packet lock: N=8, req=8'h0A, last[1]=0 for 3 grants then 1 -> gnt=8'h02 for 4 consecutive cycles (requester 3 blocked, locked=1), then gnt=8'h08; locked drops the cycle after the tail.
- Backpressure and bubble while locked:
  - Owner 2 locked, en=0 for 3 cycles -> gnt=0, owner stays 2, tmo=0.
  - Then req[2]=0 for 2 cycles with req[5]=1 -> gnt=0, requester 5 not granted.
- Timeout: LOCK_TMO=4, owner 6 drops req -> tmo=1 exactly once, on the 4th idle edge; locked=0; next cycle requester 7 (req=1) is granted.
- Reset mid-packet: reset asserted while locked with owner 3 -> next cycle locked=0, ptr=0; with req=8'hFF the first grant goes to requester 0.
